sd_stream_scheduler: RTL and testbench
======================================

// Module: sd_stream_scheduler
// PURPOSE
//  Sequences the SD card block-read engine for audio streaming: issues continuous multi-block reads,
//  captures bytes into a 2-bank (ping-pong) block buffer, presents them as a FWFT byte stream.
//  Applies back-pressure by dropping the continue request when no bank is free (engine stops, CMD12),
//  then re-issues from the next block address. Sits between SD read engine and sample decoder.
// PARAMETERS
//  ADDR_BITS    32   block address width (matches read engine block address)
//  COUNT_BITS   16   width of requested block count
//  BLOCK_BYTES  512  bytes per block = bytes per bank; IDX_BITS = $clog2(BLOCK_BYTES)
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           synchronous reset, active-low
//  start          in   1           1-cycle pulse: begin stream (accepted in IDLE only)
//  start_block    in   ADDR_BITS   first block address
//  block_count    in   COUNT_BITS  number of blocks to stream
//  abort          in   1           1-cycle pulse: cancel stream, no done
//  busy           out  1           high outside IDLE
//  done           out  1           1-cycle pulse: all blocks received and drained
//  error          out  1           sticky; set on card deconfigure mid-stream, cleared by start
//  card_configured in  1           read engine configured
//  card_ready     in   1           read engine idle, accepting trigger
//  rd_trigger     out  1           read request / continue request to engine
//  rd_continuous  out  1           continuous mode select (always 1 while rd_trigger)
//  rd_block_addr  out  ADDR_BITS   start block address of request
//  rd_data        in   8           received byte
//  rd_idx         in   IDX_BITS    byte index within block
//  rd_new         in   1           rd_data/rd_idx valid this cycle
//  out_data       out  8           stream byte (valid while out_valid)
//  out_valid      out  1           drain bank holds unread byte
//  out_ready      in   1           consumer accept; transfer when out_valid & out_ready
// BEHAVIOUR
//  Reset: state IDLE; busy=0 done=0 error=0 rd_trigger=0 rd_continuous=0 rd_block_addr=0
//   out_valid=0; both bank-full flags 0; fill/drain bank=0; read pointer=0. Buffer contents undefined.
//  Regs: next_addr, remaining (blocks not yet fully received), fill_bank, drain_bank, full[1:0], rptr.
//  Capture: rd_new -> mem[fill_bank][rd_idx] <= rd_data; on rd_new & rd_idx==BLOCK_BYTES-1:
//   full[fill_bank]<=1, fill_bank toggles, remaining-1, next_addr+1 (wraps mod 2^ADDR_BITS).
//  Drain: out_valid = full[drain_bank]; out_data = mem[drain_bank][rptr] (FWFT, comb read).
//   Transfer: rptr+1; at rptr==BLOCK_BYTES-1: full[drain_bank]<=0, drain_bank toggles, rptr<=0.
//   Same-cycle set (capture) and clear (drain) hit different banks; never conflict.
//  FSM:
//   IDLE   : start & card_configured -> latch next_addr=start_block, remaining=block_count, error<=0;
//            block_count==0 -> done pulse, stay IDLE; else -> ISSUE. start & !card_configured -> error<=1.
//   ISSUE  : rd_trigger = card_ready & !full[fill_bank]; rd_block_addr=next_addr;
//            card_ready falls -> STREAM.
//   STREAM : rd_trigger = !card_ready & remaining!=0 & !full[fill_bank] (continue request, engine
//            samples it at end of each block's CRC); card_ready rises -> remaining==0 ? DRAIN : ISSUE.
//   DRAIN  : full==2'b00 -> done pulse, -> IDLE.
//   FLUSH  : rd_trigger=0; wait card_ready -> clear full, rptr, banks -> IDLE (no done).
//  abort (any non-IDLE state) -> FLUSH; bytes arriving in FLUSH are discarded.
//  card_configured falling in ISSUE/STREAM/DRAIN -> error<=1, -> FLUSH (exits when engine re-ready).
//  start while busy ignored. abort and start same cycle in IDLE: start wins.
//  rd_trigger never high in IDLE/DRAIN/FLUSH; never high while card_ready in STREAM.
// CONFIGURATION
//  SD_STREAM_UNDERRUN_CNT_EN defined: extra port underrun_cnt out 16; counts cycles with
//   busy & out_ready & !out_valid, saturating at 16'hFFFF, cleared on start acceptance and reset.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  T1 start(100,1), engine model, consumer always ready -> trigger at addr 100, 512 bytes out in idx
//   order, continue request low at CRC, done one cycle after last byte drained.
//  T2 start(7,4), consumer always ready -> single request addr 7, 4 blocks, 2048 bytes, one done.
//  T3 start(0,5), out_ready=0 until two banks full -> continue low after block 2, engine stops;
//   release ready -> re-issue at addr 2, total 5 blocks in order, done.
//  T4 abort mid block 2 of start(0,8) -> FLUSH, no done, out_valid=0 after card_ready; new start OK.
//  T5 start with block_count=0 -> done next cycle, rd_trigger never asserted; start_block 2^32-1,
//   count 2 -> second block address 0.
//  T6 card_configured drops mid-stream -> error=1, FLUSH; with _EN, underrun_cnt counts stall cycles.

Source files
------------

// File: rtl/sd_stream_scheduler.sv
// Streams SD multi-block reads through a two-bank ping-pong block buffer into a FWFT byte stream.
// Optional feature macro: SD_STREAM_UNDERRUN_CNT_EN adds the underrun_cnt output.
module sd_stream_scheduler #(
  parameter  int ADDR_BITS   = 32,
  parameter  int COUNT_BITS  = 16,
  parameter  int BLOCK_BYTES = 512,
  localparam int IDX_BITS    = $clog2(BLOCK_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  start_block,
  input  logic [COUNT_BITS-1:0] block_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  card_configured,
  input  logic                  card_ready,
  output logic                  rd_trigger,
  output logic                  rd_continuous,
  output logic [ADDR_BITS-1:0]  rd_block_addr,
  input  logic [7:0]            rd_data,
  input  logic [IDX_BITS-1:0]   rd_idx,
  input  logic                  rd_new,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SD_STREAM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_STREAM, S_DRAIN, S_FLUSH} state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  next_addr_q, next_addr_d;
  logic [COUNT_BITS-1:0] remaining_q, remaining_d;
  logic                  fill_bank_q, fill_bank_d;
  logic                  drain_bank_q, drain_bank_d;
  logic [1:0]            full_q, full_d;
  logic [IDX_BITS-1:0]   rptr_q, rptr_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;

  logic [7:0] mem [2*BLOCK_BYTES];

  logic capture, block_end, xfer, drain_end;

  assign capture   = rd_new && (state_q == S_ISSUE || state_q == S_STREAM);
  assign block_end = capture && (rd_idx == IDX_BITS'(BLOCK_BYTES - 1));
  assign out_valid = full_q[drain_bank_q];
  assign out_data  = mem[{drain_bank_q, rptr_q}];
  assign xfer      = out_valid && out_ready;
  assign drain_end = xfer && (rptr_q == IDX_BITS'(BLOCK_BYTES - 1));

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign rd_block_addr = next_addr_q;
  assign rd_continuous = rd_trigger;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    next_addr_d  = next_addr_q;
    remaining_d  = remaining_q;
    fill_bank_d  = fill_bank_q;
    drain_bank_d = drain_bank_q;
    full_d       = full_q;
    rptr_d       = rptr_q;
    error_d      = error_q;
    done_d       = 1'b0;
    rd_trigger   = 1'b0;

    // Fill and drain always touch different banks, so set and clear never collide.
    if (block_end) begin
      full_d[fill_bank_q] = 1'b1;
      fill_bank_d         = ~fill_bank_q;
      next_addr_d         = next_addr_q + ADDR_BITS'(1);
      if (remaining_q != '0) remaining_d = remaining_q - COUNT_BITS'(1);
    end
    if (drain_end) begin
      full_d[drain_bank_q] = 1'b0;
      drain_bank_d         = ~drain_bank_q;
      rptr_d               = '0;
    end else if (xfer) begin
      rptr_d = rptr_q + IDX_BITS'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (card_configured) begin
            next_addr_d = start_block;
            remaining_d = block_count;
            error_d     = 1'b0;
            if (block_count == '0) done_d  = 1'b1;
            else                   state_d = S_ISSUE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        rd_trigger = card_ready && !full_q[fill_bank_q];
        if (!card_ready) state_d = S_STREAM;
      end
      S_STREAM: begin
        // Continue request: the engine samples it after each block's CRC.
        rd_trigger = !card_ready && (remaining_q != '0) && !full_q[fill_bank_q];
        if (card_ready) state_d = (remaining_q == '0) ? S_DRAIN : S_ISSUE;
      end
      S_DRAIN: begin
        if (full_d == 2'b00) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (card_ready) begin
          full_d       = 2'b00;
          rptr_d       = '0;
          fill_bank_d  = 1'b0;
          drain_bank_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q inside {S_ISSUE, S_STREAM, S_DRAIN}) begin
      if (abort) begin
        state_d    = S_FLUSH;
        done_d     = 1'b0;
        rd_trigger = 1'b0;
      end else if (!card_configured) begin
        error_d    = 1'b1;
        state_d    = S_FLUSH;
        done_d     = 1'b0;
        rd_trigger = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      next_addr_q  <= '0;
      remaining_q  <= '0;
      fill_bank_q  <= 1'b0;
      drain_bank_q <= 1'b0;
      full_q       <= 2'b00;
      rptr_q       <= '0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      remaining_q  <= remaining_d;
      fill_bank_q  <= fill_bank_d;
      drain_bank_q <= drain_bank_d;
      full_q       <= full_d;
      rptr_q       <= rptr_d;
      error_q      <= error_d;
      done_q       <= done_d;
    end
  end

  // NOTE: buffer storage is not reset; the full flags alone decide what is readable.
  always_ff @(posedge clk) begin
    if (capture) mem[{fill_bank_q, rd_idx}] <= rd_data;
  end

`ifdef SD_STREAM_UNDERRUN_CNT_EN
  logic [15:0] underrun_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_q <= '0;
    end else if (state_q == S_IDLE && start && card_configured) begin
      underrun_q <= '0;
    end else if (busy && out_ready && !out_valid && underrun_q != 16'hFFFF) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_sd_stream_scheduler.sv
// Self-checking bench for sd_stream_scheduler: SD engine model, expected-byte queue, per-cycle compare.
module tb_sd_stream_scheduler;
  localparam int BB = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_block = '0;
  logic [15:0] block_count = '0;
  logic        abort = 1'b0;
  logic        busy, done, error;
  logic        card_configured = 1'b1;
  logic        card_ready;
  logic        rd_trigger, rd_continuous;
  logic [31:0] rd_block_addr;
  logic [7:0]  rd_data;
  logic [8:0]  rd_idx;
  logic        rd_new;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef SD_STREAM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
  logic [15:0] uc_model = '0;
`endif

  always #5 clk = ~clk;

  sd_stream_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_block(start_block),
    .block_count(block_count), .abort(abort), .busy(busy), .done(done), .error(error),
    .card_configured(card_configured), .card_ready(card_ready), .rd_trigger(rd_trigger),
    .rd_continuous(rd_continuous), .rd_block_addr(rd_block_addr), .rd_data(rd_data),
    .rd_idx(rd_idx), .rd_new(rd_new), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SD_STREAM_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_due = -1;
  int          done_cnt = 0;
  bit          chk_en = 1'b1;
  bit          seen_first = 1'b0;
  logic [7:0]  first_data = '0;
  logic [7:0]  last_data = '0;
  logic [7:0]  exp_q[$];
  logic [31:0] req_log[$];
  int          eng_blocks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Card content: each block's bytes are a fixed function of its address and byte index.
  function automatic logic [7:0] blk_byte(input logic [31:0] a, input int i);
    logic [31:0] v;
    v = a * 32'd37 + 32'(i) * 32'd5 + 32'(i / 256);
    return v[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_test(input logic [31:0] sb, input int cnt, input bit expect_data);
    req_log.delete();
    exp_q.delete();
    eng_blocks = 0;
    done_cnt   = 0;
    seen_first = 1'b0;
    chk_en     = expect_data;
    if (expect_data)
      for (int b = 0; b < cnt; b++)
        for (int i = 0; i < BB; i++) exp_q.push_back(blk_byte(sb + 32'(b), i));
  endtask

  task automatic do_start(input logic [31:0] sb, input logic [15:0] cnt);
    start_block = sb;
    block_count = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    repeat (3) tick();
  endtask

  task automatic wait_blocks(input string name, input int nb, input int limit);
    int n = 0;
    while (eng_blocks < nb && n < limit) begin
      tick();
      n++;
    end
    check({name, "_blocks_timeout"}, 32'(eng_blocks >= nb), 32'd1);
  endtask

  // SD read engine: accepts a trigger while ready, streams blocks, samples continue after CRC.
  initial begin : engine
    logic [31:0] a;
    bit cont;
    card_ready = 1'b1;
    rd_new = 1'b0;
    rd_data = '0;
    rd_idx = '0;
    forever begin
      @(negedge clk);
      if (rst_n && card_ready && rd_trigger === 1'b1) begin
        a = rd_block_addr;
        req_log.push_back(a);
        tick();
        card_ready = 1'b0;
        cont = 1'b1;
        while (cont) begin
          repeat (2) tick();
          for (int i = 0; i < BB; i++) begin
            rd_new = 1'b1;
            rd_idx = 9'(i);
            rd_data = blk_byte(a, i);
            tick();
          end
          rd_new = 1'b0;
          eng_blocks++;
          repeat (3) tick();
          @(negedge clk);
          cont = (rd_trigger === 1'b1);
          tick();
          a = a + 32'd1;
        end
        repeat (4) tick();
        card_ready = 1'b1;
      end
    end
  end

  // Per-cycle compare against the expected stream, done timing and trigger rules.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      check("trig_while_idle", 32'(rd_trigger & ~busy), 32'd0);
      if (rd_trigger) check("rd_continuous", 32'(rd_continuous), 32'd1);
      check("done", 32'(done), 32'(cyc == done_due));
      if (done) done_cnt++;
      if (out_valid && out_ready && chk_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(out_valid), 32'd0);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0]));
          if (!seen_first) first_data = out_data;
          seen_first = 1'b1;
          last_data = out_data;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_due = cyc + 1;
        end
      end
      if (start && !busy && card_configured && block_count == 16'd0) done_due = cyc + 1;
`ifdef SD_STREAM_UNDERRUN_CNT_EN
      check("underrun_cnt", 32'(underrun_cnt), 32'(uc_model));
      if (start && !busy && card_configured) uc_model = '0;
      else if (busy && out_ready && !out_valid && uc_model != 16'hFFFF) uc_model = uc_model + 16'd1;
`endif
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_trigger", 32'(rd_trigger), 32'd0);
    check("rst_continuous", 32'(rd_continuous), 32'd0);
    check("rst_addr", rd_block_addr, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: one block at 100
    out_ready = 1'b1;
    begin_test(32'd100, 1, 1'b1);
    do_start(32'd100, 16'd1);
    wait_idle("t1", 5000);
    check("t1_req_cnt", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) check("t1_req_addr", req_log[0], 32'd100);
    check("t1_first_byte", 32'(first_data), 32'd116);
    check("t1_last_byte", 32'(last_data), 32'd112);
    check("t1_left", 32'(exp_q.size()), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_eng_blocks", 32'(eng_blocks), 32'd1);

    // T2: four blocks in one continuous request
    begin_test(32'd7, 4, 1'b1);
    do_start(32'd7, 16'd4);
    wait_idle("t2", 8000);
    check("t2_req_cnt", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) check("t2_req_addr", req_log[0], 32'd7);
    check("t2_left", 32'(exp_q.size()), 32'd0);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // T3: consumer stalled until both banks full, then re-issue at block 2
    out_ready = 1'b0;
    begin_test(32'd0, 5, 1'b1);
    do_start(32'd0, 16'd5);
    begin
      int n = 0;
      while (!(eng_blocks == 2 && card_ready) && n < 5000) begin
        tick();
        n++;
      end
    end
    repeat (20) tick();
    check("t3_stall_blocks", 32'(eng_blocks), 32'd2);
    check("t3_stall_trigger", 32'(rd_trigger), 32'd0);
    check("t3_stall_valid", 32'(out_valid), 32'd1);
    check("t3_stall_busy", 32'(busy), 32'd1);
    check("t3_stall_reqs", 32'(req_log.size()), 32'd1);
    out_ready = 1'b1;
    wait_idle("t3", 10000);
    check("t3_req_cnt", 32'(req_log.size()), 32'd2);
    if (req_log.size() > 1) check("t3_reissue_addr", req_log[1], 32'd2);
    check("t3_left", 32'(exp_q.size()), 32'd0);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);

    // T4: abort mid second block
    begin_test(32'd0, 8, 1'b0);
    do_start(32'd0, 16'd8);
    wait_blocks("t4", 1, 3000);
    repeat (100) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle("t4", 3000);
    check("t4_card_ready", 32'(card_ready), 32'd1);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'd0);
    check("t4_error", 32'(error), 32'd0);
    check("t4_eng_blocks", 32'(eng_blocks), 32'd2);

    // T5: zero-length stream, then address wrap
    begin_test(32'h1234, 0, 1'b1);
    do_start(32'h1234, 16'd0);
    repeat (5) tick();
    check("t5_zero_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_zero_reqs", 32'(req_log.size()), 32'd0);
    check("t5_zero_busy", 32'(busy), 32'd0);
    begin_test(32'hFFFF_FFFF, 2, 1'b1);
    do_start(32'hFFFF_FFFF, 16'd2);
    wait_idle("t5", 5000);
    check("t5_req_cnt", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) check("t5_req_addr", req_log[0], 32'hFFFF_FFFF);
    check("t5_wrap_last_byte", 32'(last_data), 32'd252);
    check("t5_left", 32'(exp_q.size()), 32'd0);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);

    // Start while card unconfigured: error, no stream
    begin_test(32'd3, 0, 1'b0);
    card_configured = 1'b0;
    do_start(32'd3, 16'd3);
    repeat (2) tick();
    check("nocfg_error", 32'(error), 32'd1);
    check("nocfg_busy", 32'(busy), 32'd0);
    card_configured = 1'b1;

    // T6: card deconfigured mid-stream
    begin_test(32'd50, 4, 1'b0);
    do_start(32'd50, 16'd4);
    repeat (2) tick();
    check("t6_error_cleared", 32'(error), 32'd0);
    wait_blocks("t6", 1, 3000);
    repeat (50) tick();
    card_configured = 1'b0;
    wait_idle("t6", 3000);
    check("t6_error", 32'(error), 32'd1);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_done_cnt", 32'(done_cnt), 32'd0);
    check("t6_card_ready", 32'(card_ready), 32'd1);
    card_configured = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
